piso_serializer: RTL and testbench

//  Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word on a valid/ready

---
 rtl/serial_pkg.sv | 10 +
 rtl/serial_bit_counter.sv | 27 ++
 rtl/piso_serializer.sv | 113 +++++++++++
 tb/tb_piso_serializer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the serial link: FSM state encodings and the default word width.
package serial_pkg;

  localparam int SER_WIDTH = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

endpackage

// File: rtl/serial_bit_counter.sv
// Loadable down-counter with a zero flag; stops at zero, so it cannot wrap.
module serial_bit_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// MSB-first parallel-in/serial-out transmitter with valid/ready input and gapless streaming.
// Optional even-parity bit after the LSB when PIPO_PARITY_EN is defined.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// ST_IDLE   | no frame in flight; sout=0, ready to accept
// ST_SHIFT  | sending data bits, shreg MSB on sout, counter tracks bits left
// ST_PARITY | sending the parity bit (PIPO_PARITY_EN builds only)
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             w_cnt_zero;
  logic             w_last_bit;
  logic             w_accept;
  logic             w_shifting;

  assign w_shifting = (r_state == ST_SHIFT);

  serial_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (CNT_LAST),
    .i_dec      (w_shifting),
    .o_zero     (w_cnt_zero)
  );

`ifdef PIPO_PARITY_EN
  logic r_parity;

  assign w_last_bit = (r_state == ST_PARITY);

  // Parity is taken from the word as accepted, not from the shifting register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^din;
    end
  end
`else
  assign w_last_bit = w_shifting && w_cnt_zero;
`endif

  assign din_ready  = (r_state == ST_IDLE) || w_last_bit;
  assign w_accept   = din_valid && din_ready;
  assign sout_valid = (r_state != ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign done       = w_last_bit;

  always_comb begin
    sout = 1'b0;
    if (w_shifting) begin
      sout = r_shreg[WIDTH-1];
    end
`ifdef PIPO_PARITY_EN
    else if (r_state == ST_PARITY) begin
      sout = r_parity;
    end
`endif
  end

  // An accept can only occur in IDLE or on the last bit cycle, so it always starts a fresh frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
    end else if (w_accept) begin
      r_state <= ST_SHIFT;
      r_shreg <= din;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        ST_SHIFT: begin
          r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
          if (w_cnt_zero) begin
`ifdef PIPO_PARITY_EN
            r_state <= ST_PARITY;
`else
            r_state <= ST_IDLE;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed and loopback bench for piso_serializer; parity checks follow PIPO_PARITY_EN.
module tb_piso_serializer;

  localparam int WIDTH = 8;
`ifdef PIPO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] word;
    logic [7:0] bits;
    logic       par;
    int         gap;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_sout"}, 32'(sout), 32'd0);
    chk({tag, "_svalid"}, 32'(sout_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(din_ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] word, input logic [7:0] bits,
                            input logic par, input string tag);
    logic exp_bit;
    din       = word;
    din_valid = 1'b1;
    chk({tag, "_ready0"}, 32'(din_ready), 32'd1);
    tick();
    din_valid = 1'b0;
    din       = ~word;
    for (int k = 0; k < FL; k++) begin
      exp_bit = (k < WIDTH) ? bits[WIDTH-1-k] : par;
      chk({tag, "_sout"}, 32'(sout), 32'(exp_bit));
      chk({tag, "_svalid"}, 32'(sout_valid), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'(k == FL - 1));
      chk({tag, "_ready"}, 32'(din_ready), 32'(k == FL - 1));
      tick();
    end
    chk({tag, "_end_svalid"}, 32'(sout_valid), 32'd0);
  endtask

  logic [7:0] lb_q[$];
  logic [7:0] lb_cap;
  logic [7:0] lb_exp;
  logic       lb_acc;
  logic [7:0] b2b_w[2];
  logic       b2b_p[2];
  logic       b2b_bit;

  initial begin
    vecs[0] = '{word: 8'hA5, bits: 8'b1010_0101, par: 1'b0, gap: 0};
    vecs[1] = '{word: 8'h01, bits: 8'b0000_0001, par: 1'b1, gap: 5};
    vecs[2] = '{word: 8'hF0, bits: 8'b1111_0000, par: 1'b0, gap: 1};
    vecs[3] = '{word: 8'h3C, bits: 8'b0011_1100, par: 1'b0, gap: 2};
    vecs[4] = '{word: 8'hFF, bits: 8'b1111_1111, par: 1'b0, gap: 0};
    vecs[5] = '{word: 8'h80, bits: 8'b1000_0000, par: 1'b1, gap: 3};
    vecs[6] = '{word: 8'h7E, bits: 8'b0111_1110, par: 1'b0, gap: 0};
    vecs[7] = '{word: 8'h00, bits: 8'b0000_0000, par: 1'b0, gap: 5};
    b2b_w[0] = 8'hA5; b2b_p[0] = 1'b0;
    b2b_w[1] = 8'h3C; b2b_p[1] = 1'b0;

    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    #1;
    check_idle("rst_hold");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_idle("rst_rel");

    // Reset mid-frame after three bits of F0
    din       = 8'hF0;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("mid_sout", 32'(sout), 32'd1);
      chk("mid_svalid", 32'(sout_valid), 32'd1);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("arst_sout", 32'(sout), 32'd0);
    chk("arst_svalid", 32'(sout_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(din_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 12; k++) begin
      chk("arst_resid_svalid", 32'(sout_valid), 32'd0);
      chk("arst_resid_sout", 32'(sout), 32'd0);
      tick();
    end

    // Table: single frames separated by idle stalls
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].word, vecs[i].bits, vecs[i].par, "vec");
      for (int g = 0; g < vecs[i].gap; g++) begin
        check_idle("stall");
        tick();
      end
    end

    // Back-to-back A5 then 3C with din_valid held
    din       = b2b_w[0];
    din_valid = 1'b1;
    chk("b2b_ready0", 32'(din_ready), 32'd1);
    tick();
    din = b2b_w[1];
    for (int c = 1; c <= 2 * FL; c++) begin
      if (c == FL + 1) begin
        din_valid = 1'b0;
        din       = 8'h55;
      end
      b2b_bit = ((c - 1) % FL < WIDTH) ? b2b_w[(c - 1) / FL][WIDTH - 1 - ((c - 1) % FL)]
                                       : b2b_p[(c - 1) / FL];
      chk("b2b_sout", 32'(sout), 32'(b2b_bit));
      chk("b2b_svalid", 32'(sout_valid), 32'd1);
      chk("b2b_done", 32'(done), 32'((c == FL) || (c == 2 * FL)));
      chk("b2b_ready", 32'(din_ready), 32'((c == FL) || (c == 2 * FL)));
      tick();
    end
    chk("b2b_end_svalid", 32'(sout_valid), 32'd0);

    // Loopback into a SIPO capture model with random gaps
    begin
      int idx    = 0;
      int issued = 0;
      int got    = 0;
      int cyc    = 0;
      lb_cap    = '0;
      din_valid = 1'b0;
      while (got < 256 && cyc < 20000) begin
        if (sout_valid) begin
          chk("lb_done", 32'(done), 32'(idx == FL - 1));
          if (idx < WIDTH) begin
            lb_cap = {lb_cap[6:0], sout};
          end else if (lb_q.size() != 0) begin
            chk("lb_parity", 32'(sout), 32'(^lb_q[0]));
          end
          idx++;
          if (idx == FL) begin
            idx = 0;
            got++;
            if (lb_q.size() == 0) begin
              chk("lb_extra_word", 32'd1, 32'd0);
            end else begin
              lb_exp = lb_q.pop_front();
              chk("lb_word", 32'(lb_cap), 32'(lb_exp));
            end
          end
        end else begin
          chk("lb_align", 32'(idx), 32'd0);
        end
        if (!din_valid && issued < 256 && $urandom_range(0, 3) != 0) begin
          din       = 8'($urandom);
          din_valid = 1'b1;
        end
        lb_acc = din_valid && din_ready;
        if (lb_acc) begin
          lb_q.push_back(din);
          issued++;
        end
        tick();
        cyc++;
        if (lb_acc) begin
          din_valid = 1'b0;
          din       = 8'($urandom);
        end
      end
      chk("lb_count", 32'(got), 32'd256);
      chk("lb_issued", 32'(issued), 32'd256);
      chk("lb_leftover", 32'(lb_q.size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
